// File: rtl/frac_div_ctrl.sv
// frac_div_ctrl: runtime-programmable clockin/N or clockin/(N+0.5) divider controller.
// The ratio is loaded through a valid/ready handshake and only takes effect on a frame
// boundary, so clockout never glitches on a ratio change.
module frac_div_ctrl #(
   parameter int unsigned NW           = 4,
   parameter int unsigned N_MIN        = 2,
   parameter int unsigned DEFAULT_N    = 4,
   parameter bit          DEFAULT_HALF = 1'b1
) (
   input  logic          clockin,
   input  logic          reset,
   input  logic          en,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [NW-1:0] cfg_n,
   input  logic          cfg_half,
   output logic          cfg_err,
   output logic          clockout,
   output logic          frame_start,
   output logic [NW-1:0] active_n,
   output logic          active_half,
   output logic          pending
);

   // Counter holds up to 2*(2^NW-1); the half-cycle index is twice that plus one.
   localparam int unsigned   CW    = NW + 1;
   localparam int unsigned   HW    = NW + 2;
   localparam logic [NW-1:0] NMinW = NW'(N_MIN);
   localparam logic [NW-1:0] DefN  = NW'(DEFAULT_N);

   // Output level for half-cycle h of a frame: high while (h mod P) < ceil(P/2).
   // A frame never holds more than two periods, so one conditional subtract gives h mod P.
   function automatic logic level_at(input logic [HW-1:0] h, input logic [NW-1:0] n,
                                     input logic half);
      logic [HW-1:0] p;
      logic [HW-1:0] hi;
      logic [HW-1:0] hm;
      p  = {1'b0, n, half};
      hi = {2'b00, n} + {{(HW-1){1'b0}}, half};
      hm = (h >= p) ? (h - p) : h;
      return hm < hi;
   endfunction

   // Last counter value of a frame: N-1 (integer ratio) or 2N (half ratio).
   function automatic logic [CW-1:0] last_cnt(input logic [NW-1:0] n, input logic half);
      return (half ? {n, 1'b1} : {1'b0, n}) - CW'(1);
   endfunction

   logic [CW-1:0] cnt_q, cnt_d, cnt_nx, last_q;
   logic          run_q, run_d;
   logic          x_q, x_d;
   logic          y_q, y_d;
   logic          fs_q, fs_d;
   logic          err_q, err_d;
   logic          pend_q, pend_d;
   logic [NW-1:0] pend_n_q, pend_n_d;
   logic          pend_half_q, pend_half_d;
   logic [NW-1:0] act_n_q, act_n_d;
   logic          act_half_q, act_half_d;
   logic          wrap, boundary, xfer, legal, apply;

   // Next-state decode for the posedge stage and the negedge retiming term.
   always_comb begin
      last_q   = last_cnt(act_n_q, act_half_q);
      wrap     = run_q && (cnt_q >= last_q);
      boundary = !run_q || wrap;
      xfer     = cfg_valid && !pend_q;
      legal    = cfg_n >= NMinW;
      apply    = pend_q && (!en || boundary);

      act_n_d     = act_n_q;
      act_half_d  = act_half_q;
      pend_d      = pend_q;
      pend_n_d    = pend_n_q;
      pend_half_d = pend_half_q;
      if (apply) begin
         act_n_d    = pend_n_q;
         act_half_d = pend_half_q;
         pend_d     = 1'b0;
      end
      // xfer needs pend_q=0, so it never collides with apply on the same edge.
      if (xfer && legal) begin
         pend_d      = 1'b1;
         pend_n_d    = cfg_n;
         pend_half_d = cfg_half;
      end
      err_d = xfer && !legal;

      run_d = en;
      cnt_d = (en && !boundary) ? (cnt_q + CW'(1)) : '0;
      fs_d  = en && boundary;

      // Posedge term: high for the whole coming cycle only when both halves are high.
      x_d = en && level_at({cnt_d, 1'b0}, act_n_d, act_half_d)
               && level_at({cnt_d, 1'b1}, act_n_d, act_half_d);

      // Negedge term: covers the second half of this cycle when the high run continues into
      // the first half of the next one. A frame always starts high, so predicting the next
      // count with the current ratio is exact across a ratio change.
      cnt_nx = (cnt_q >= last_q) ? '0 : (cnt_q + CW'(1));
      y_d    = run_q && level_at({cnt_q, 1'b1}, act_n_q, act_half_q)
                     && level_at({cnt_nx, 1'b0}, act_n_q, act_half_q);
   end

   // Posedge state: frame counter, ratio registers, handshake and posedge clock term.
   always_ff @(posedge clockin) begin
      if (reset) begin
         cnt_q       <= '0;
         run_q       <= 1'b0;
         x_q         <= 1'b0;
         fs_q        <= 1'b0;
         err_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_n_q    <= DefN;
         pend_half_q <= DEFAULT_HALF;
         act_n_q     <= DefN;
         act_half_q  <= DEFAULT_HALF;
      end else begin
         cnt_q       <= cnt_d;
         run_q       <= run_d;
         x_q         <= x_d;
         fs_q        <= fs_d;
         err_q       <= err_d;
         pend_q      <= pend_d;
         pend_n_q    <= pend_n_d;
         pend_half_q <= pend_half_d;
         act_n_q     <= act_n_d;
         act_half_q  <= act_half_d;
      end
   end

   // Negedge retiming of the second-half clock term.
   always_ff @(negedge clockin) begin
      if (reset) begin
         y_q <= 1'b0;
      end else begin
         y_q <= y_d;
      end
   end

   // Gating with run_q forces clockout low from the posedge that samples en=0.
   assign clockout    = x_q | (y_q & run_q);
   assign cfg_ready   = ~pend_q;
   assign cfg_err     = err_q;
   assign frame_start = fs_q;
   assign active_n    = act_n_q;
   assign active_half = act_half_q;
   assign pending     = pend_q;

endmodule
